// File: rtl/qdr_mbist_sequencer.sv
// Two-pass address-pattern BIST sequencer for the QDR-II+ SRAM test mux.
// Pass 0 writes and reads the true pattern and pass 1 the inverted pattern; returned data is checked in order.
module qdr_mbist_sequencer #(
    parameter int unsigned ADDR_BITS = 18,
    parameter int unsigned DATA_BITS = 144,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk_ram_ctl,
    input  logic                 rst_n,
    input  logic                 mbist_start,
    output logic                 ram_wr_en_bist,
    output logic [ADDR_BITS-1:0] ram_wr_addr_bist,
    output logic [DATA_BITS-1:0] ram_wr_data_bist,
    output logic                 ram_rd_en_bist,
    output logic [ADDR_BITS-1:0] ram_rd_addr_bist,
    input  logic                 ram_rd_valid,
    input  logic [DATA_BITS-1:0] ram_rd_data,
    output logic                 mbist_busy,
    output logic                 mbist_done,
    output logic                 mbist_fail,
    output logic [15:0]          mbist_err_count,
    output logic [ADDR_BITS-1:0] mbist_fail_addr
);

    localparam int unsigned OUT_BITS = ADDR_BITS + 1;
    localparam int unsigned ERR_BITS = 16;
    localparam int unsigned SUM_BITS = ERR_BITS + 1;
    localparam int unsigned TMO_BITS = $clog2(TIMEOUT + 1);
    localparam int unsigned REPS     = (DATA_BITS + ADDR_BITS - 1) / ADDR_BITS;

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_e;

    // Address replicated from the LSB up, truncated, optionally inverted.
    function automatic logic [DATA_BITS-1:0] pattern(input logic [ADDR_BITS-1:0] a, input logic inv);
        logic [REPS*ADDR_BITS-1:0] rep;
        rep = {REPS{a}};
        return rep[DATA_BITS-1:0] ^ {DATA_BITS{inv}};
    endfunction

    state_e               state_q, state_d;
    logic                 p_q, p_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] exp_q, exp_d;
    logic [OUT_BITS-1:0]  outst_q, outst_d;
    logic [TMO_BITS-1:0]  tmo_q, tmo_d;
    logic                 wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
    logic                 rd_en_q, rd_en_d;
    logic [ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic [ERR_BITS-1:0]  err_q, err_d;
    logic [ADDR_BITS-1:0] faddr_q, faddr_d;

    logic                 spurious, mismatch, timeout, clear;
    logic [1:0]           err_inc;
    logic [SUM_BITS-1:0]  err_sum;

    always_comb begin
        state_d   = state_q;
        p_d       = p_q;
        addr_d    = addr_q;
        exp_d     = exp_q;
        outst_d   = outst_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        fail_d    = fail_q;
        err_d     = err_q;
        faddr_d   = faddr_q;
        timeout   = 1'b0;
        clear     = 1'b0;
        err_inc   = 2'd0;
        err_sum   = '0;

        // A return with nothing outstanding is an error but is never compared against a pattern.
        spurious = ram_rd_valid && (outst_q == '0);
        mismatch = ram_rd_valid && !spurious && (ram_rd_data != pattern(exp_q, p_q));

        if (ram_rd_valid) begin
            exp_d = exp_q + ADDR_BITS'(1);
        end
        if (rd_en_q && !(ram_rd_valid && !spurious)) begin
            outst_d = outst_q + OUT_BITS'(1);
        end else if (!rd_en_q && ram_rd_valid && !spurious) begin
            outst_d = outst_q - OUT_BITS'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (mbist_start) begin
                    state_d = S_WRITE;
                    p_d     = 1'b0;
                    addr_d  = '0;
                    busy_d  = 1'b1;
                    clear   = 1'b1;
                end
            end
            S_WRITE: begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = pattern(addr_q, p_q);
                addr_d    = addr_q + ADDR_BITS'(1);
                if (addr_q == '1) begin
                    state_d = S_READ;
                    exp_d   = '0;
                end
            end
            S_READ: begin
                rd_en_d   = 1'b1;
                rd_addr_d = addr_q;
                addr_d    = addr_q + ADDR_BITS'(1);
                if (addr_q == '1) begin
                    state_d = S_DRAIN;
                    tmo_d   = '0;
                end
            end
            S_DRAIN: begin
                // The final read strobe is still in the output register on the first drain cycle.
                if (outst_q == '0 && !rd_en_q) begin
                    if (p_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_WRITE;
                        p_d     = 1'b1;
                    end
                end else if (tmo_q == TMO_BITS'(TIMEOUT - 1)) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q + TMO_BITS'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Result registers: cleared by an accepted start, otherwise accumulate errors.
        if (clear) begin
            fail_d  = 1'b0;
            err_d   = '0;
            faddr_d = '0;
        end else begin
            err_inc = 2'(mismatch | spurious) + 2'(timeout);
            if (err_inc != 2'd0) begin
                fail_d  = 1'b1;
                err_sum = {1'b0, err_q} + SUM_BITS'(err_inc);
                err_d   = err_sum[ERR_BITS] ? '1 : err_sum[ERR_BITS-1:0];
            end
            if (mismatch && !fail_q) begin
                faddr_d = exp_q;
            end
        end
    end

    always_ff @(posedge clk_ram_ctl) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            p_q       <= 1'b0;
            addr_q    <= '0;
            exp_q     <= '0;
            outst_q   <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
            err_q     <= '0;
            faddr_q   <= '0;
        end else begin
            state_q   <= state_d;
            p_q       <= p_d;
            addr_q    <= addr_d;
            exp_q     <= exp_d;
            outst_q   <= outst_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
            err_q     <= err_d;
            faddr_q   <= faddr_d;
        end
    end

    assign ram_wr_en_bist   = wr_en_q;
    assign ram_wr_addr_bist = wr_addr_q;
    assign ram_wr_data_bist = wr_data_q;
    assign ram_rd_en_bist   = rd_en_q;
    assign ram_rd_addr_bist = rd_addr_q;
    assign mbist_busy       = busy_q;
    assign mbist_done       = done_q;
    assign mbist_fail       = fail_q;
    assign mbist_err_count  = err_q;
    assign mbist_fail_addr  = faddr_q;

endmodule

// File: tb/tb_qdr_mbist_sequencer.sv
// Bench for qdr_mbist_sequencer: 16-word RAM model with 5-cycle read latency and fault injection.
module tb_qdr_mbist_sequencer;

    localparam int unsigned AB  = 4;
    localparam int unsigned DB  = 16;
    localparam int unsigned TMO = 64;
    localparam int unsigned LAT = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mbist_start;
    logic          ram_wr_en_bist;
    logic [AB-1:0] ram_wr_addr_bist;
    logic [DB-1:0] ram_wr_data_bist;
    logic          ram_rd_en_bist;
    logic [AB-1:0] ram_rd_addr_bist;
    logic          ram_rd_valid;
    logic [DB-1:0] ram_rd_data;
    logic          mbist_busy;
    logic          mbist_done;
    logic          mbist_fail;
    logic [15:0]   mbist_err_count;
    logic [AB-1:0] mbist_fail_addr;

    logic stuck, noret, spur;

    always #5 clk = ~clk;

    qdr_mbist_sequencer #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TMO)) dut (
        .clk_ram_ctl      (clk),
        .rst_n            (rst_n),
        .mbist_start      (mbist_start),
        .ram_wr_en_bist   (ram_wr_en_bist),
        .ram_wr_addr_bist (ram_wr_addr_bist),
        .ram_wr_data_bist (ram_wr_data_bist),
        .ram_rd_en_bist   (ram_rd_en_bist),
        .ram_rd_addr_bist (ram_rd_addr_bist),
        .ram_rd_valid     (ram_rd_valid),
        .ram_rd_data      (ram_rd_data),
        .mbist_busy       (mbist_busy),
        .mbist_done       (mbist_done),
        .mbist_fail       (mbist_fail),
        .mbist_err_count  (mbist_err_count),
        .mbist_fail_addr  (mbist_fail_addr)
    );

    // RAM model: storage plus a fixed-latency in-order read pipeline.
    logic [DB-1:0]  mem [16];
    logic [LAT-1:0] pv;
    logic [AB-1:0]  pa [LAT];

    always @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            if (ram_wr_en_bist) mem[ram_wr_addr_bist] <= ram_wr_data_bist;
            pv    <= {pv[LAT-2:0], ram_rd_en_bist};
            pa[0] <= ram_rd_addr_bist;
            for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
        end
    end

    assign ram_rd_valid = (pv[LAT-1] && !noret) || spur;
    assign ram_rd_data  = mem[pa[LAT-1]] | ((stuck && pa[LAT-1] == 4'd6) ? 16'h0001 : 16'h0000);

    function automatic logic [DB-1:0] tb_pat(input logic [AB-1:0] a, input logic inv);
        return {4{a}} ^ {DB{inv}};
    endfunction

    // Monitor: counts strobes and done pulses, checks write/read sequencing within a run.
    int          wr_cnt = 0, rd_cnt = 0, done_cnt = 0, wr_bad = 0, rd_bad = 0;
    int          wseq = 0, rseq = 0;
    logic [DB-1:0] w3 [2];

    always @(negedge clk) begin
        if (mbist_done) done_cnt <= done_cnt + 1;
        if (!mbist_busy) begin
            wseq <= 0;
            rseq <= 0;
        end else begin
            if (ram_wr_en_bist) begin
                if (ram_wr_addr_bist != 4'(wseq) || ram_wr_data_bist != tb_pat(4'(wseq), wseq >= 16))
                    wr_bad <= wr_bad + 1;
                if (ram_wr_addr_bist == 4'd3) w3[wseq >= 16 ? 1 : 0] <= ram_wr_data_bist;
                wr_cnt <= wr_cnt + 1;
                wseq   <= wseq + 1;
            end
            if (ram_rd_en_bist) begin
                if (ram_rd_addr_bist != 4'(rseq)) rd_bad <= rd_bad + 1;
                rd_cnt <= rd_cnt + 1;
                rseq   <= rseq + 1;
            end
        end
    end

    int passed = 0, total = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        mbist_start = 1'b1;
        @(negedge clk);
        mbist_start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (mbist_done) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic        stuck;
        logic        noret;
        logic        exp_fail;
        logic [15:0] exp_err;
        logic [3:0]  exp_faddr;
        int          exp_wr;
        int          exp_rd;
    } vec_t;

    vec_t vt [3];

    initial begin
        bit ok;
        int w0, r0, d0, wb0, rb0;

        rst_n = 1'b0; mbist_start = 1'b0; stuck = 1'b0; noret = 1'b0; spur = 1'b0;

        vt[0] = '{1'b0, 1'b0, 1'b0, 16'd0, 4'd0, 32, 32};
        vt[1] = '{1'b1, 1'b0, 1'b1, 16'd1, 4'd6, 32, 32};
        vt[2] = '{1'b0, 1'b1, 1'b1, 16'd1, 4'd0, 16, 16};

        do_reset();
        chk("reset_busy", mbist_busy, 0);
        chk("reset_done", mbist_done, 0);
        chk("reset_fail", mbist_fail, 0);
        chk("reset_err", mbist_err_count, 0);
        chk("reset_wr_en", ram_wr_en_bist, 0);
        chk("reset_rd_en", ram_rd_en_bist, 0);

        for (int v = 0; v < 3; v++) begin
            stuck = vt[v].stuck;
            noret = vt[v].noret;
            do_reset();
            w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt; wb0 = wr_bad; rb0 = rd_bad;
            pulse_start();
            chk($sformatf("v%0d_busy_after_start", v), mbist_busy, 1);
            wait_done(ok);
            chk($sformatf("v%0d_done_seen", v), ok, 1);
            chk($sformatf("v%0d_busy_at_done", v), mbist_busy, 0);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_fail", v), mbist_fail, vt[v].exp_fail);
            chk($sformatf("v%0d_err_count", v), mbist_err_count, vt[v].exp_err);
            chk($sformatf("v%0d_fail_addr", v), mbist_fail_addr, vt[v].exp_faddr);
            chk($sformatf("v%0d_done_pulses", v), done_cnt - d0, 1);
            chk($sformatf("v%0d_writes", v), wr_cnt - w0, vt[v].exp_wr);
            chk($sformatf("v%0d_reads", v), rd_cnt - r0, vt[v].exp_rd);
            chk($sformatf("v%0d_wr_seq_errs", v), wr_bad - wb0, 0);
            chk($sformatf("v%0d_rd_seq_errs", v), rd_bad - rb0, 0);
            if (v == 0) begin
                chk("v0_wdata_a3_pass0", w3[0], 16'h3333);
                chk("v0_wdata_a3_pass1", w3[1], 16'hCCCC);
            end
        end
        stuck = 1'b0;
        noret = 1'b0;

        // Spurious return in IDLE, then a start that clears it and a second start ignored mid-WRITE.
        do_reset();
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        @(negedge clk);
        chk("spur_err", mbist_err_count, 1);
        chk("spur_fail", mbist_fail, 1);
        chk("spur_fail_addr", mbist_fail_addr, 0);
        chk("spur_busy", mbist_busy, 0);
        w0 = wr_cnt; d0 = done_cnt;
        pulse_start();
        chk("start_clears_err", mbist_err_count, 0);
        chk("start_clears_fail", mbist_fail, 0);
        repeat (4) @(negedge clk);
        chk("in_write", ram_wr_en_bist, 1);
        pulse_start();
        wait_done(ok);
        chk("dbl_done_seen", ok, 1);
        repeat (3) @(negedge clk);
        chk("dbl_done_pulses", done_cnt - d0, 1);
        chk("dbl_writes", wr_cnt - w0, 32);
        chk("dbl_fail", mbist_fail, 0);
        chk("dbl_err", mbist_err_count, 0);

        // Reset pulse in the middle of the read phase.
        do_reset();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ram_rd_en_bist) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_reached_read", ok, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", ram_wr_en_bist, 0);
        chk("rst_rd_en", ram_rd_en_bist, 0);
        chk("rst_busy", mbist_busy, 0);
        chk("rst_done", mbist_done, 0);
        rst_n = 1'b1;
        w0 = wr_cnt; r0 = rd_cnt; d0 = done_cnt;
        repeat (100) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_idle_writes", wr_cnt - w0, 0);
        chk("rst_idle_reads", rd_cnt - r0, 0);
        chk("rst_idle_busy", mbist_busy, 0);
        chk("rst_err", mbist_err_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
